// File: rtl/capture_uart_sequencer.sv
// capture_uart_sequencer
// Arms a capture block, waits for a finished frame, then drains the frame
// buffer FIFO word by word and streams it to a UART as:
//   0x55, 0xAA, {hi, lo} x WORDS_PER_FRAME, 8-bit payload sum.
// Waits for the capture block or for FIFO data are bounded by TIMEOUT_CYC;
// UART back-pressure is not bounded.
//
// Ports
//   iClk, iRst_N     clock, async active-low reset
//   iStart           one-cycle frame request (honoured only when idle)
//   oCap_En          capture enable, high while armed
//   iFrameDone       capture finished (honoured only while armed)
//   oFIFO_Rst        one-cycle FIFO flush (frame start or timeout abort)
//   oFIFO_Rd_En      FIFO read strobe, data arrives on iFIFO_Rd_Data next cycle
//   iFIFO_Rd_Data    FIFO read data
//   iFIFO_Empty      FIFO empty flag
//   oTx_Data/oTx_Valid/iTx_Ready   byte stream to the UART (valid/ready)
//   oBusy            not idle
//   oDone            one-cycle pulse after the checksum byte is accepted
//   oErr             one-cycle pulse on timeout abort
module capture_uart_sequencer #(
  parameter logic [15:0] WORDS_PER_FRAME = 16'd49152,
  parameter logic [23:0] TIMEOUT_CYC     = 24'd12000000
) (
  input  logic        iClk,
  input  logic        iRst_N,
  input  logic        iStart,
  output logic        oCap_En,
  input  logic        iFrameDone,
  output logic        oFIFO_Rst,
  output logic        oFIFO_Rd_En,
  input  logic [15:0] iFIFO_Rd_Data,
  input  logic        iFIFO_Empty,
  output logic [7:0]  oTx_Data,
  output logic        oTx_Valid,
  input  logic        iTx_Ready,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH, S_ARM, S_HDR0, S_HDR1, S_RD, S_LAT, S_TXH, S_TXL, S_CSUM, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_wcnt;
  logic [15:0] r_hold;
  logic [7:0]  r_csum;
  logic [23:0] r_timer;

  logic        w_timing;
  logic        w_timeout;
  logic        w_xfer;
  logic [16:0] w_wcnt_inc;

  // Timer only runs while waiting on the capture block or on FIFO data.
  always_comb begin
    w_timing   = (r_state == S_ARM) || ((r_state == S_RD) && iFIFO_Empty);
    w_timeout  = w_timing && (r_timer == (TIMEOUT_CYC - 24'd1));
    // one extra bit so the last-word compare happens before any wrap
    w_wcnt_inc = {1'b0, r_wcnt} + 17'd1;
  end

  always_comb begin
    oTx_Valid = 1'b0;
    oTx_Data  = 8'h00;
    case (r_state)
      S_HDR0: begin oTx_Valid = 1'b1; oTx_Data = 8'h55;         end
      S_HDR1: begin oTx_Valid = 1'b1; oTx_Data = 8'hAA;         end
      S_TXH:  begin oTx_Valid = 1'b1; oTx_Data = r_hold[15:8];  end
      S_TXL:  begin oTx_Valid = 1'b1; oTx_Data = r_hold[7:0];   end
      S_CSUM: begin oTx_Valid = 1'b1; oTx_Data = r_csum;        end
      default: ;
    endcase
    w_xfer = oTx_Valid && iTx_Ready;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (iStart) w_next = S_FLUSH;
      S_FLUSH: w_next = S_ARM;
      S_ARM:   if (w_timeout) w_next = S_IDLE;
               else if (iFrameDone) w_next = S_HDR0;
      S_HDR0:  if (w_xfer) w_next = S_HDR1;
      S_HDR1:  if (w_xfer) w_next = S_RD;
      S_RD:    if (w_timeout) w_next = S_IDLE;
               else if (!iFIFO_Empty) w_next = S_LAT;
      S_LAT:   w_next = S_TXH;
      S_TXH:   if (w_xfer) w_next = S_TXL;
      S_TXL:   if (w_xfer) w_next = (w_wcnt_inc == {1'b0, WORDS_PER_FRAME}) ? S_CSUM : S_RD;
      S_CSUM:  if (w_xfer) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oCap_En     = (r_state == S_ARM) && !w_timeout;
    oFIFO_Rst   = (r_state == S_FLUSH) || w_timeout;
    oFIFO_Rd_En = (r_state == S_RD) && !iFIFO_Empty;
    oBusy       = (r_state != S_IDLE);
    oDone       = (r_state == S_DONE);
    oErr        = w_timeout;
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state <= S_IDLE;
      r_wcnt  <= 16'd0;
      r_hold  <= 16'd0;
      r_csum  <= 8'd0;
      r_timer <= 24'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_timer <= 24'd0;
      else if (w_timing)     r_timer <= r_timer + 24'd1;

      case (r_state)
        S_FLUSH: begin
          r_wcnt <= 16'd0;
          r_csum <= 8'd0;
        end
        S_LAT: r_hold <= iFIFO_Rd_Data;
        S_TXH: if (w_xfer) r_csum <= r_csum + r_hold[15:8];
        S_TXL: if (w_xfer) begin
          r_csum <= r_csum + r_hold[7:0];
          r_wcnt <= w_wcnt_inc[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule
